card_tracker: RTL and testbench

CARD_TRACKER -- requirements
Module: card_tracker

---
 rtl/card_tracker.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_card_tracker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/card_tracker.sv
// card_tracker: blackjack shoe tracker.
// Counts the decks in the shoe, the cards dealt per rank and the running count
// under four counting systems. Keeps a short undo history, and derives the true
// count (running * 52 / remaining) with a multi-cycle restoring divider.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   deck_add              add one deck (only while nothing is dealt)
//   shuffle               clear all dealt state, keep the decks
//   card_valid, card_rank deal one card (1=Ace, 2..9, 10=ten-value)
//   back                  undo the most recent card
//   mode                  counting system, latched while total==0
//   query_rank            rank looked up on query_left
//   deck, total, remaining, running        shoe state
//   true_count, tc_valid  divider result and its freshness flag
//   reject                one-cycle pulse for a refused action
//   hist_cnt              number of undoable cards held
//   query_left            combinational cards of query_rank still in the shoe
module card_tracker #(
    parameter int unsigned MAX_DECKS  = 8,
    parameter int unsigned UNDO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               deck_add,
    input  logic                               shuffle,
    input  logic                               card_valid,
    input  logic [3:0]                         card_rank,
    input  logic                               back,
    input  logic [1:0]                         mode,
    input  logic [3:0]                         query_rank,
    output logic [7:0]                         deck,
    output logic [15:0]                        total,
    output logic [15:0]                        remaining,
    output logic signed [15:0]                 running,
    output logic signed [7:0]                  true_count,
    output logic                               tc_valid,
    output logic                               reject,
    output logic [$clog2(UNDO_DEPTH+1)-1:0]    hist_cnt,
    output logic [15:0]                        query_left
);

    localparam int unsigned HC_W      = $clog2(UNDO_DEPTH + 1);
    localparam int unsigned PTR_W     = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned QW        = 22;
    localparam int unsigned DIV_STEPS = 22;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV} div_state_t;

    // Per-rank count weight under the selected counting system.
    function automatic logic signed [2:0] weight(input logic [3:0] r, input logic [1:0] m);
        logic signed [2:0] w;
        w = 3'sd0;
        case (m)
            2'b00: begin
                if (r >= 4'd2 && r <= 4'd6)        w = 3'sd1;
                else if (r == 4'd1 || r == 4'd10)  w = -3'sd1;
            end
            2'b01: begin
                if (r >= 4'd2 && r <= 4'd7)        w = 3'sd1;
                else if (r == 4'd1 || r == 4'd10)  w = -3'sd1;
            end
            2'b10: begin
                if (r >= 4'd3 && r <= 4'd6)        w = 3'sd1;
                else if (r == 4'd10)               w = -3'sd1;
            end
            default: begin
                if (r == 4'd2 || r == 4'd3 || r == 4'd7) w = 3'sd1;
                else if (r >= 4'd4 && r <= 4'd6)         w = 3'sd2;
                else if (r == 4'd9)                      w = -3'sd1;
                else if (r == 4'd10)                     w = -3'sd2;
            end
        endcase
        return w;
    endfunction

    // Cards of rank r in a shoe of d decks; zero for an invalid rank.
    function automatic logic [CNT_W-1:0] capacity(input logic [3:0] r, input logic [7:0] d);
        logic [CNT_W-1:0] c;
        c = '0;
        if (r >= 4'd1 && r <= 4'd9) c = CNT_W'(d) << 2;
        else if (r == 4'd10)        c = CNT_W'(d) << 4;
        return c;
    endfunction

    logic [7:0]              deck_q, deck_d;
    logic [15:0]             total_q, total_d;
    logic [15:0]             remaining_q, remaining_d;
    logic signed [15:0]      running_q, running_d;
    logic signed [7:0]       tc_q, tc_d;
    logic                    tc_valid_q, tc_valid_d;
    logic                    reject_q, reject_d;
    logic [HC_W-1:0]         hist_cnt_q, hist_cnt_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]              mode_q, mode_d;
    logic [CNT_W-1:0]        dealt_q [1:10];
    logic [CNT_W-1:0]        dealt_d [1:10];
    logic [3:0]              hist_q [0:UNDO_DEPTH-1];
    logic [3:0]              hist_d [0:UNDO_DEPTH-1];
    div_state_t              state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [QW-1:0]           quo_q, quo_d;
    logic [15:0]             rem_q, rem_d;
    logic [15:0]             div_q, div_d;
    logic                    neg_q, neg_d;

    logic [CNT_W-1:0]        card_dealt;
    logic [CNT_W-1:0]        query_dealt;
    logic [PTR_W-1:0]        pop_ptr;
    logic [3:0]              pop_rank;
    logic [16:0]             run_ext;
    logic [16:0]             run_abs;
    logic [16:0]             trial;
    logic                    qbit;
    logic signed [7:0]       tc_res;
    logic signed [2:0]       w_card;
    logic signed [2:0]       w_pop;
    logic                    update;

    // Dealt-count lookups for the incoming card and the query port.
    always_comb begin
        card_dealt  = '0;
        query_dealt = '0;
        for (int i = 1; i <= 10; i++) begin
            if (card_rank == 4'(i))  card_dealt  = dealt_q[i];
            if (query_rank == 4'(i)) query_dealt = dealt_q[i];
        end
    end

    assign query_left = capacity(query_rank, deck_q) - query_dealt;

    assign pop_ptr  = (wr_ptr_q == '0) ? PTR_W'(UNDO_DEPTH - 1) : wr_ptr_q - PTR_W'(1);
    assign pop_rank = hist_q[pop_ptr];
    assign w_card   = weight(card_rank, mode_q);
    assign w_pop    = weight(pop_rank, mode_q);
    assign run_ext  = {running_q[15], running_q};
    assign run_abs  = running_q[15] ? (~run_ext + 17'd1) : run_ext;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign trial = {rem_q, quo_q[QW-1]};
    assign qbit  = (trial >= {1'b0, div_q});

    // Sign, truncation toward zero and saturation of the unsigned quotient.
    always_comb begin
        tc_res = '0;
        if (div_q != '0) begin
            if (neg_q) tc_res = (quo_q >= QW'(128)) ? 8'sh80 : 8'(~quo_q[7:0] + 8'd1);
            else       tc_res = (quo_q > QW'(127))  ? 8'sh7F : quo_q[7:0];
        end
    end

    // Next-state logic: divider progress first, then the single accepted action.
    always_comb begin
        deck_d     = deck_q;
        total_d    = total_q;
        running_d  = running_q;
        tc_d       = tc_q;
        tc_valid_d = tc_valid_q;
        reject_d   = 1'b0;
        hist_cnt_d = hist_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        mode_d     = mode_q;
        dealt_d    = dealt_q;
        hist_d     = hist_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        div_d      = div_q;
        neg_d      = neg_q;
        update     = 1'b0;

        if (total_q == '0) mode_d = mode;

        case (state_q)
            S_LOAD: begin
                div_d   = remaining_q;
                neg_d   = running_q[15];
                quo_d   = QW'(run_abs) * QW'(52);
                rem_d   = '0;
                cnt_d   = '0;
                state_d = S_DIV;
            end
            S_DIV: begin
                if (cnt_q == 5'(DIV_STEPS)) begin
                    tc_d       = tc_res;
                    tc_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    rem_d = qbit ? 16'(trial - {1'b0, div_q}) : trial[15:0];
                    quo_d = {quo_q[QW-2:0], qbit};
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: ;
        endcase

        if (shuffle) begin
            total_d    = '0;
            running_d  = '0;
            hist_cnt_d = '0;
            wr_ptr_d   = '0;
            for (int i = 1; i <= 10; i++) dealt_d[i] = '0;
            tc_d       = '0;
            tc_valid_d = 1'b1;
            state_d    = S_IDLE;
        end else if (deck_add) begin
            if (total_q == '0 && deck_q < 8'(MAX_DECKS)) begin
                deck_d = deck_q + 8'd1;
                update = 1'b1;
            end else begin
                reject_d = 1'b1;
            end
        end else if (back) begin
            if (hist_cnt_q != '0) begin
                for (int i = 1; i <= 10; i++)
                    if (pop_rank == 4'(i)) dealt_d[i] = dealt_q[i] - CNT_W'(1);
                total_d    = total_q - 16'd1;
                running_d  = running_q - {{13{w_pop[2]}}, w_pop};
                hist_cnt_d = hist_cnt_q - HC_W'(1);
                wr_ptr_d   = pop_ptr;
                update     = 1'b1;
            end else begin
                reject_d = 1'b1;
            end
        end else if (card_valid) begin
            if (deck_q != '0 && card_rank >= 4'd1 && card_rank <= 4'd10 &&
                card_dealt != capacity(card_rank, deck_q)) begin
                for (int i = 1; i <= 10; i++)
                    if (card_rank == 4'(i)) dealt_d[i] = dealt_q[i] + CNT_W'(1);
                total_d          = total_q + 16'd1;
                running_d        = running_q + {{13{w_card[2]}}, w_card};
                hist_d[wr_ptr_q] = card_rank;
                wr_ptr_d         = (wr_ptr_q == PTR_W'(UNDO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                hist_cnt_d       = (hist_cnt_q == HC_W'(UNDO_DEPTH)) ? hist_cnt_q
                                                                      : hist_cnt_q + HC_W'(1);
                update           = 1'b1;
            end else begin
                reject_d = 1'b1;
            end
        end

        // Any accepted change invalidates the result and restarts the divider.
        if (update) begin
            tc_valid_d = 1'b0;
            state_d    = S_LOAD;
        end

        remaining_d = 16'(52) * 16'(deck_d) - total_d;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deck_q      <= '0;
            total_q     <= '0;
            remaining_q <= '0;
            running_q   <= '0;
            tc_q        <= '0;
            tc_valid_q  <= 1'b1;
            reject_q    <= 1'b0;
            hist_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            mode_q      <= '0;
            dealt_q     <= '{default: '0};
            hist_q      <= '{default: '0};
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            neg_q       <= 1'b0;
        end else begin
            deck_q      <= deck_d;
            total_q     <= total_d;
            remaining_q <= remaining_d;
            running_q   <= running_d;
            tc_q        <= tc_d;
            tc_valid_q  <= tc_valid_d;
            reject_q    <= reject_d;
            hist_cnt_q  <= hist_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            mode_q      <= mode_d;
            dealt_q     <= dealt_d;
            hist_q      <= hist_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            neg_q       <= neg_d;
        end
    end

    assign deck       = deck_q;
    assign total      = total_q;
    assign remaining  = remaining_q;
    assign running    = running_q;
    assign true_count = tc_q;
    assign tc_valid   = tc_valid_q;
    assign reject     = reject_q;
    assign hist_cnt   = hist_cnt_q;

endmodule

// File: tb/tb_card_tracker.sv
// Directed self-checking bench for card_tracker (MAX_DECKS=3, UNDO_DEPTH=4).
module tb_card_tracker;

    localparam int unsigned MAXD  = 3;
    localparam int unsigned UNDOD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              deck_add, shuffle, card_valid, back;
    logic [3:0]        card_rank, query_rank;
    logic [1:0]        mode;
    logic [7:0]        deck;
    logic [15:0]       total, remaining, query_left;
    logic signed [15:0] running;
    logic signed [7:0] true_count;
    logic              tc_valid, reject;
    logic [$clog2(UNDOD+1)-1:0] hist_cnt;

    int checks   = 0;
    int failures = 0;

    card_tracker #(.MAX_DECKS(MAXD), .UNDO_DEPTH(UNDOD)) dut (
        .clk(clk), .rst(rst), .deck_add(deck_add), .shuffle(shuffle),
        .card_valid(card_valid), .card_rank(card_rank), .back(back), .mode(mode),
        .query_rank(query_rank), .deck(deck), .total(total), .remaining(remaining),
        .running(running), .true_count(true_count), .tc_valid(tc_valid),
        .reject(reject), .hist_cnt(hist_cnt), .query_left(query_left)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic act(input logic da, input logic sh, input logic bk,
                       input logic cv, input logic [3:0] rk);
        deck_add = da; shuffle = sh; back = bk; card_valid = cv; card_rank = rk;
        tick();
        deck_add = 1'b0; shuffle = 1'b0; back = 1'b0; card_valid = 1'b0; card_rank = 4'd0;
    endtask

    task automatic deal(input logic [3:0] rk);
        act(1'b0, 1'b0, 1'b0, 1'b1, rk);
    endtask

    task automatic chk_reset_state(input string ph);
        chk({ph, "_deck"},     32'(deck), 0);
        chk({ph, "_total"},    32'(total), 0);
        chk({ph, "_remain"},   32'(remaining), 0);
        chk({ph, "_running"},  32'(running), 0);
        chk({ph, "_tc"},       32'(true_count), 0);
        chk({ph, "_tcvalid"},  32'(tc_valid), 1);
        chk({ph, "_reject"},   32'(reject), 0);
        chk({ph, "_histcnt"},  32'(hist_cnt), 0);
    endtask

    initial begin
        rst = 1'b1; deck_add = 1'b0; shuffle = 1'b0; card_valid = 1'b0; back = 1'b0;
        card_rank = 4'd0; mode = 2'b00; query_rank = 4'd0;
        #2;
        chk_reset_state("rst");
        tick(); tick();
        rst = 1'b0;

        // Hi-Lo, four fives in one deck, then a refused fifth five.
        act(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("add_deck", 32'(deck), 1);
        chk("add_remain", 32'(remaining), 52);
        chk("add_tcvalid", 32'(tc_valid), 0);
        for (int i = 0; i < 4; i++) deal(4'd5);
        chk("hl_total", 32'(total), 4);
        chk("hl_running", 32'(running), 4);
        chk("hl_remain", 32'(remaining), 48);
        chk("hl_histcnt", 32'(hist_cnt), 4);
        repeat (23) tick();
        chk("hl_tcv_n23", 32'(tc_valid), 0);
        tick();
        chk("hl_tcv_n24", 32'(tc_valid), 1);
        chk("hl_tc", 32'(true_count), 4);
        query_rank = 4'd5;  #1 chk("q_rank5", 32'(query_left), 0);
        query_rank = 4'd10; #1 chk("q_rank10", 32'(query_left), 16);
        query_rank = 4'd11; #1 chk("q_rank11", 32'(query_left), 0);
        deal(4'd5);
        chk("cap_reject", 32'(reject), 1);
        chk("cap_total", 32'(total), 4);
        chk("cap_running", 32'(running), 4);
        chk("cap_tcvalid", 32'(tc_valid), 1);
        tick();
        chk("reject_pulse", 32'(reject), 0);

        // Shuffle ten cycles into a division.
        deal(4'd2);
        chk("sh_pre_running", 32'(running), 5);
        repeat (9) tick();
        act(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("sh_total", 32'(total), 0);
        chk("sh_running", 32'(running), 0);
        chk("sh_tc", 32'(true_count), 0);
        chk("sh_tcvalid", 32'(tc_valid), 1);
        chk("sh_deck", 32'(deck), 1);
        chk("sh_remain", 32'(remaining), 52);
        chk("sh_histcnt", 32'(hist_cnt), 0);
        repeat (20) tick();
        chk("sh_abort_tcv", 32'(tc_valid), 1);
        chk("sh_abort_tc", 32'(true_count), 0);
        query_rank = 4'd5; #1 chk("q_after_sh", 32'(query_left), 4);

        // Omega II latched at total 0; later mode change is ignored.
        mode = 2'b11; tick();
        deal(4'd4); deal(4'd10); deal(4'd9);
        chk("om_running", 32'(running), -1);
        chk("om_total", 32'(total), 3);
        mode = 2'b00; tick();
        act(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("om_back_running", 32'(running), 0);
        chk("om_back_total", 32'(total), 2);
        deal(4'd9);
        chk("om_redeal_running", 32'(running), -1);
        repeat (24) tick();
        chk("om_tcvalid", 32'(tc_valid), 1);
        chk("om_tc_neg", 32'(true_count), -1);

        // Undo history depth 4 with six cards dealt.
        act(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        for (int r = 2; r <= 7; r++) deal(4'(r));
        chk("un_running", 32'(running), 5);
        chk("un_histcnt", 32'(hist_cnt), 4);
        for (int i = 0; i < 4; i++) act(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("un_total", 32'(total), 2);
        chk("un_running2", 32'(running), 2);
        chk("un_histcnt0", 32'(hist_cnt), 0);
        act(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("un_reject", 32'(reject), 1);
        chk("un_rej_total", 32'(total), 2);
        query_rank = 4'd7; #1 chk("q_rank7", 32'(query_left), 4);
        repeat (23) tick();
        chk("un_tcvalid", 32'(tc_valid), 1);
        chk("un_tc", 32'(true_count), 2);

        // Omega II truncation: 24*52/40 = 31.2.
        act(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        mode = 2'b11; tick();
        for (int r = 4; r <= 6; r++) for (int k = 0; k < 4; k++) deal(4'(r));
        chk("om2_running", 32'(running), 24);
        repeat (24) tick();
        chk("om2_tc", 32'(true_count), 31);

        // KO full deck: remaining 0 forces true_count 0.
        act(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        mode = 2'b01; tick();
        for (int r = 1; r <= 10; r++) for (int k = 0; k < ((r == 10) ? 16 : 4); k++) deal(4'(r));
        chk("ko_running", 32'(running), 4);
        chk("ko_remain", 32'(remaining), 0);
        deal(4'd3);
        chk("ko_empty_reject", 32'(reject), 1);
        repeat (23) tick();
        chk("ko_tcvalid", 32'(tc_valid), 1);
        chk("ko_tc_zero", 32'(true_count), 0);

        // Deck limit and priority.
        act(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        act(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("lim_deck2", 32'(deck), 2);
        act(1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
        chk("pri_deck", 32'(deck), 3);
        chk("pri_reject", 32'(reject), 0);
        chk("pri_total", 32'(total), 0);
        act(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("lim_reject", 32'(reject), 1);
        chk("lim_deck3", 32'(deck), 3);
        deal(4'd10);
        act(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("dealt_add_reject", 32'(reject), 1);
        chk("dealt_remain", 32'(remaining), 155);
        chk("dealt_running", 32'(running), -1);

        // Asynchronous reset in the middle of a division.
        deal(4'd3);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1 chk_reset_state("arst");
        #2 rst = 1'b0;
        repeat (30) tick();
        chk("arst_idle_tcv", 32'(tc_valid), 1);
        chk("arst_idle_tc", 32'(true_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
